// File: rtl/chip8_fb_arbiter_if.sv
// chip8_fb_arbiter_if -- bus bundle between the framebuffer arbiter and its
// three neighbours: video scanout, CPU op port and the single-port
// framebuffer RAM.
//   vid_*  : pixel request (x 0..63, y 0..31) and registered pixel reply
//   cpu_*  : valid/ready op port (read, write, xor-write, clear) with done pulse
//   mem_*  : 256-byte RAM port, byte = row*8 + x/8, MSB = leftmost pixel
// Modports: slave = arbiter side, master = environment (scanout/CPU/RAM).
interface chip8_fb_arbiter_if;
  logic       vid_req_in;
  logic [5:0] vid_x_in;
  logic [4:0] vid_y_in;
  logic       vid_pixel_out;
  logic       vid_valid_out;

  logic       cpu_valid_in;
  logic       cpu_ready_out;
  logic [1:0] cpu_op_in;
  logic [7:0] cpu_addr_in;
  logic [7:0] cpu_wdata_in;
  logic [7:0] cpu_rdata_out;
  logic       cpu_done_out;
  logic       cpu_collision_out;

  logic [7:0] mem_addr_out;
  logic       mem_we_out;
  logic [7:0] mem_wdata_out;
  logic [7:0] mem_rdata_in;

  modport slave (
    input  vid_req_in, vid_x_in, vid_y_in,
    input  cpu_valid_in, cpu_op_in, cpu_addr_in, cpu_wdata_in,
    input  mem_rdata_in,
    output vid_pixel_out, vid_valid_out,
    output cpu_ready_out, cpu_rdata_out, cpu_done_out, cpu_collision_out,
    output mem_addr_out, mem_we_out, mem_wdata_out
  );

  modport master (
    output vid_req_in, vid_x_in, vid_y_in,
    output cpu_valid_in, cpu_op_in, cpu_addr_in, cpu_wdata_in,
    output mem_rdata_in,
    input  vid_pixel_out, vid_valid_out,
    input  cpu_ready_out, cpu_rdata_out, cpu_done_out, cpu_collision_out,
    input  mem_addr_out, mem_we_out, mem_wdata_out
  );
endinterface

// File: rtl/chip8_fb_arbiter.sv
// chip8_fb_arbiter -- shares one single-port framebuffer RAM between video
// scanout and the CPU.
//   clk_in   : clock, all state on rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : chip8_fb_arbiter_if.slave (video, CPU op and RAM ports)
// Parameter READ_LAT (1..3): RAM read latency; an address presented in
// cycle c returns data on mem_rdata_in in cycle c+READ_LAT.
// Build option: define FB_CLEAR_ENGINE_EN to include the hardware clear
// engine (op 11); otherwise op 11 is a no-op that completes next cycle.
// Video is served from a one-byte cache whose tag is the RAM byte address;
// any write that lands on the cached byte updates it in the same cycle, so
// a hit always reflects RAM contents.
module chip8_fb_arbiter #(
  parameter int READ_LAT = 2
) (
  input logic               clk_in,
  input logic               rst_n_in,
  chip8_fb_arbiter_if.slave bus
);
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [7:0] LAST_WAIT = 8'(READ_LAT);

  typedef enum logic [2:0] {
    IDLE, VID_RD, CPU_RD, CPU_WR
`ifdef FB_CLEAR_ENGINE_EN
    , CLEAR
`endif
  } state_t;

  state_t     state, nxt;
  logic [7:0] cnt;         // read wait count, or clear address
  logic [7:0] fill_addr;
  logic [1:0] op;
  logic [7:0] op_addr;
  logic [7:0] wr_data;     // write data; for xor becomes old^wdata
  logic       xor_coll;
  logic [7:0] cache_tag, cache_data;
  logic       cache_vld;
  logic       rdy_en;      // keeps ready low until first clock after reset
  logic [7:0] vid_addr;
  logic       hit, miss, ready, xfer;

  assign vid_addr = {bus.vid_y_in, bus.vid_x_in[5:3]};
  assign hit      = cache_vld && (cache_tag == vid_addr);
  assign miss     = bus.vid_req_in && !hit;
  // a miss seen in IDLE wins the port, so the CPU is held off that cycle
  assign ready    = rdy_en && (state == IDLE) && !miss;
  assign xfer     = ready && bus.cpu_valid_in;
  assign bus.cpu_ready_out = ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt               = state;
    bus.mem_addr_out  = '0;
    bus.mem_we_out    = 1'b0;
    bus.mem_wdata_out = '0;
    case (state)
      IDLE: begin
        if (miss) nxt = VID_RD;
        else if (xfer) begin
          case (bus.cpu_op_in)
            OP_RD, OP_XOR: nxt = CPU_RD;
            OP_WR:         nxt = CPU_WR;
`ifdef FB_CLEAR_ENGINE_EN
            default:       nxt = CLEAR;
`else
            default:       nxt = IDLE;
`endif
          endcase
        end
      end
      VID_RD: begin
        bus.mem_addr_out = fill_addr;
        if (cnt == LAST_WAIT) nxt = IDLE;
      end
      CPU_RD: begin
        bus.mem_addr_out = op_addr;
        if (cnt == LAST_WAIT) nxt = (op == OP_XOR) ? CPU_WR : IDLE;
      end
      CPU_WR: begin
        bus.mem_addr_out  = op_addr;
        bus.mem_we_out    = 1'b1;
        bus.mem_wdata_out = wr_data;
        nxt               = IDLE;
      end
`ifdef FB_CLEAR_ENGINE_EN
      CLEAR: begin
        bus.mem_addr_out = cnt;
        bus.mem_we_out   = 1'b1;
        if (cnt == 8'hFF) nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt                   <= '0;
      fill_addr             <= '0;
      op                    <= '0;
      op_addr               <= '0;
      wr_data               <= '0;
      xor_coll              <= 1'b0;
      cache_tag             <= '0;
      cache_data            <= '0;
      cache_vld             <= 1'b0;
      rdy_en                <= 1'b0;
      bus.vid_pixel_out     <= 1'b0;
      bus.vid_valid_out     <= 1'b0;
      bus.cpu_rdata_out     <= '0;
      bus.cpu_done_out      <= 1'b0;
      bus.cpu_collision_out <= 1'b0;
    end else begin
      rdy_en                <= 1'b1;
      bus.cpu_done_out      <= 1'b0;
      bus.cpu_collision_out <= 1'b0;
      // hits are answered in every state; misses report invalid
      bus.vid_valid_out <= bus.vid_req_in && hit;
      bus.vid_pixel_out <= bus.vid_req_in && hit &&
                           cache_data[3'd7 - bus.vid_x_in[2:0]];
      case (state)
        IDLE: begin
          cnt <= '0;
          if (miss) fill_addr <= vid_addr;
          else if (xfer) begin
            op      <= bus.cpu_op_in;
            op_addr <= bus.cpu_addr_in;
            wr_data <= bus.cpu_wdata_in;
`ifndef FB_CLEAR_ENGINE_EN
            if (bus.cpu_op_in == 2'b11) bus.cpu_done_out <= 1'b1;
`endif
          end
        end
        VID_RD: begin
          cnt <= cnt + 8'd1;
          if (cnt == LAST_WAIT) begin
            cache_tag  <= fill_addr;
            cache_data <= bus.mem_rdata_in;
            cache_vld  <= 1'b1;
          end
        end
        CPU_RD: begin
          cnt <= cnt + 8'd1;
          if (cnt == LAST_WAIT) begin
            if (op == OP_RD) begin
              bus.cpu_rdata_out <= bus.mem_rdata_in;
              bus.cpu_done_out  <= 1'b1;
            end else begin
              wr_data  <= bus.mem_rdata_in ^ wr_data;
              xor_coll <= |(bus.mem_rdata_in & wr_data);
            end
          end
        end
        CPU_WR: begin
          bus.cpu_done_out      <= 1'b1;
          bus.cpu_collision_out <= (op == OP_XOR) && xor_coll;
          if (op_addr == cache_tag) cache_data <= wr_data;
        end
`ifdef FB_CLEAR_ENGINE_EN
        CLEAR: begin
          cnt <= cnt + 8'd1;
          if (cnt == cache_tag) cache_data <= '0;
          if (cnt == 8'hFF) bus.cpu_done_out <= 1'b1;
        end
`endif
        default: cnt <= '0;
      endcase
    end
  end
endmodule
